// File: rtl/lycan_rx_arbiter_pkg.sv
// Shared configuration for the lycan RX arbiter: packet geometry, peripheral
// count and the round-robin pointer helper.
package lycan_globals;

  localparam int unsigned usb_packet_width     = 16;
  localparam int unsigned periph_address_width = 4;
  localparam int unsigned num_peripherals      = 4;

  // Payload carried by each peripheral; the address is prepended on output.
  localparam int unsigned payload_width = usb_packet_width - periph_address_width;

  // Pointer width is kept at least 1 so a single-peripheral build stays legal.
  localparam int unsigned ptr_width = (num_peripherals > 32'd1) ? $clog2(num_peripherals) : 32'd1;

  typedef logic [payload_width-1:0] payload_t;
  typedef logic [ptr_width-1:0]     ptr_t;

  // Advance a peripheral index by one, wrapping at num_peripherals.
  function automatic ptr_t ptr_wrap_inc(input ptr_t p);
    ptr_t r;
    if (32'(p) >= (num_peripherals - 32'd1)) begin
      r = '0;
    end else begin
      r = p + ptr_t'(1'b1);
    end
    return r;
  endfunction

endpackage

// File: rtl/lycan_rx_arbiter_periph_rx_buffer.sv
// Two-entry FIFO holding peripheral payloads. A push while full is ignored,
// a pop while empty is ignored; push+pop at count 1 replaces the head.
module periph_rx_buffer
  import lycan_globals::*;
#(
  parameter int unsigned W = payload_width
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o,
  output logic         full_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         do_push_s;
  logic         do_pop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    do_push_s = push_i && (count_q != 2'd2);
    do_pop_s  = pop_i && (count_q != 2'd0);
  end

  // Storage and occupancy update; head_q is always the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q <= data_i;
          end else begin
            tail_q <= data_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable at count 1 (push is blocked when full):
          // the old head leaves and the new word becomes the head.
          if (count_q == 2'd1) begin
            head_q <= data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= data_i;
          end
        end
        default: begin
          head_q <= head_q;
        end
      endcase
    end
  end

  assign data_o  = head_q;
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/lycan_rx_arbiter.sv
// Round-robin merge of per-peripheral RX buffers into a single USB TX stream.
// Each granted packet is {peripheral index, payload} and is presented as a
// one-cycle strobe on the registered USB output.
module lycan_rx_arbiter
  import lycan_globals::*;
(
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [num_peripherals-1:0][payload_width-1:0]   periph_rx_data,
  input  logic [num_peripherals-1:0]                      periph_rx_valid,
  output logic [num_peripherals-1:0]                      periph_rx_fifo_full,
  output logic [usb_packet_width-1:0]                     usb_tx_data,
  output logic                                            usb_tx_valid,
  input  logic                                            usb_tx_full,
  output logic [num_peripherals-1:0]                      rx_overflow,
  input  logic [num_peripherals-1:0]                      overflow_clear,
  output logic                                            idle
);

  // Every peripheral index must be representable in the address field.
  if (num_peripherals > (32'd1 << periph_address_width)) begin : g_bad_cfg
    $error("lycan_rx_arbiter: num_peripherals exceeds address space");
  end

  payload_t                   head_s  [num_peripherals];
  logic [1:0]                 count_s [num_peripherals];
  logic [num_peripherals-1:0] push_s;
  logic [num_peripherals-1:0] pop_s;
  logic [num_peripherals-1:0] full_s;
  logic [num_peripherals-1:0] ovf_set_s;

  ptr_t                        rr_q;
  ptr_t                        rr_d;
  logic                        tx_valid_q;
  logic                        tx_valid_d;
  logic [usb_packet_width-1:0] tx_data_q;
  logic [usb_packet_width-1:0] tx_data_d;
  logic [num_peripherals-1:0]  ovf_q;
  logic [num_peripherals-1:0]  ovf_d;

  logic        grant_s;
  ptr_t        grant_idx_s;
  logic [31:0] scan_sum_s;
  ptr_t        scan_idx_s;
  logic        scan_hit_s;

  for (genvar gi = 0; gi < num_peripherals; gi++) begin : g_buf
    assign push_s[gi]    = periph_rx_valid[gi] && (count_s[gi] != 2'd2);
    assign ovf_set_s[gi] = periph_rx_valid[gi] && (count_s[gi] == 2'd2);
    assign pop_s[gi]     = grant_s && (grant_idx_s == ptr_t'(gi));

    periph_rx_buffer #(.W(payload_width)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s[gi]),
      .pop_i   (pop_s[gi]),
      .data_i  (periph_rx_data[gi]),
      .data_o  (head_s[gi]),
      .count_o (count_s[gi]),
      .full_o  (full_s[gi])
    );
  end

  // Round-robin search: first non-empty buffer at or after rr_q, wrapping.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = '0;
    scan_sum_s  = 32'd0;
    scan_idx_s  = '0;
    scan_hit_s  = 1'b0;
    for (int k = 0; k < num_peripherals; k++) begin
      scan_sum_s  = 32'(rr_q) + 32'(k);
      scan_idx_s  = ptr_t'((scan_sum_s >= num_peripherals) ? (scan_sum_s - num_peripherals) : scan_sum_s);
      scan_hit_s  = !grant_s && (count_s[scan_idx_s] != 2'd0);
      grant_idx_s = scan_hit_s ? scan_idx_s : grant_idx_s;
      grant_s     = grant_s | scan_hit_s;
    end
    // A full USB FIFO blocks the grant entirely, freezing buffers and rr_q.
    grant_s = grant_s & ~usb_tx_full;
  end

  // Next-state for the output stage, pointer and sticky overflow flags.
  always_comb begin
    if (grant_s) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {periph_address_width'(grant_idx_s), head_s[grant_idx_s]};
      rr_d       = ptr_wrap_inc(grant_idx_s);
    end else begin
      tx_valid_d = 1'b0;
      tx_data_d  = tx_data_q;
      rr_d       = rr_q;
    end
    // A drop in the same cycle as a clear wins.
    ovf_d = ovf_set_s | (ovf_q & ~overflow_clear);
  end

  // Registered output stage, round-robin pointer and overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rr_q       <= '0;
      ovf_q      <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rr_q       <= rr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Idle when every buffer is empty and nothing is being presented.
  always_comb begin
    idle = !tx_valid_q;
    for (int i = 0; i < num_peripherals; i++) begin
      idle = idle && (count_s[i] == 2'd0);
    end
  end

  assign periph_rx_fifo_full = full_s;
  assign usb_tx_data         = tx_data_q;
  assign usb_tx_valid        = tx_valid_q;
  assign rx_overflow         = ovf_q;

endmodule

// File: tb/tb_lycan_rx_arbiter.sv
// Self-checking bench for lycan_rx_arbiter: directed scenarios plus a random
// run, all compared against a queue-style reference model.
module tb_lycan_rx_arbiter;
  import lycan_globals::*;

  localparam int NP = num_peripherals;
  localparam int PW = payload_width;
  localparam int UW = usb_packet_width;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0][PW-1:0] periph_rx_data;
  logic [NP-1:0] periph_rx_valid;
  logic [NP-1:0] periph_rx_fifo_full;
  logic [UW-1:0] usb_tx_data;
  logic usb_tx_valid;
  logic usb_tx_full;
  logic [NP-1:0] rx_overflow;
  logic [NP-1:0] overflow_clear;
  logic idle;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-peripheral list of up to two payloads.
  logic [PW-1:0] m_buf [NP][2];
  int            m_cnt [NP];
  int            m_rr;
  logic          m_valid;
  logic [UW-1:0] m_data;
  logic [NP-1:0] m_ovf;

  always #5 clk = ~clk;

  lycan_rx_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .periph_rx_data      (periph_rx_data),
    .periph_rx_valid     (periph_rx_valid),
    .periph_rx_fifo_full (periph_rx_fifo_full),
    .usb_tx_data         (usb_tx_data),
    .usb_tx_valid        (usb_tx_valid),
    .usb_tx_full         (usb_tx_full),
    .rx_overflow         (rx_overflow),
    .overflow_clear      (overflow_clear),
    .idle                (idle)
  );

  function automatic logic exp_idle();
    logic r;
    r = !m_valid;
    for (int i = 0; i < NP; i++) if (m_cnt[i] != 0) r = 1'b0;
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_full();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = (m_cnt[i] == 2);
    return r;
  endfunction

  // Apply the current inputs to the model as one clock edge.
  task automatic model_step();
    int pre [NP];
    int g;
    logic [NP-1:0] set;
    if (rst) begin
      for (int i = 0; i < NP; i++) m_cnt[i] = 0;
      m_rr = 0; m_valid = 1'b0; m_data = '0; m_ovf = '0;
    end else begin
      for (int i = 0; i < NP; i++) pre[i] = m_cnt[i];
      g = -1;
      if (!usb_tx_full) begin
        for (int k = 0; k < NP; k++) begin
          int c;
          c = (m_rr + k) % NP;
          if (g < 0 && pre[c] > 0) g = c;
        end
      end
      if (g >= 0) begin
        m_data = {periph_address_width'(g), m_buf[g][0]};
        m_buf[g][0] = m_buf[g][1];
        m_cnt[g] = m_cnt[g] - 1;
        m_valid = 1'b1;
        m_rr = (g + 1) % NP;
      end else begin
        m_valid = 1'b0;
      end
      set = '0;
      for (int i = 0; i < NP; i++) begin
        if (periph_rx_valid[i]) begin
          if (pre[i] < 2) begin
            m_buf[i][m_cnt[i]] = periph_rx_data[i];
            m_cnt[i] = m_cnt[i] + 1;
          end else begin
            set[i] = 1'b1;
          end
        end
      end
      m_ovf = set | (m_ovf & ~overflow_clear);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    periph_rx_valid = '0;
    overflow_clear  = '0;
    for (int i = 0; i < NP; i++) periph_rx_data[i] = PW'($urandom);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; usb_tx_full = 1'b0; overflow_clear = '0;
    periph_rx_valid = '1;
    for (int i = 0; i < NP; i++) periph_rx_data[i] = PW'($urandom);
    tick();
    tick();
    rst = 1'b0;
    clear_inputs();
    n_tests++; if (usb_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", usb_tx_valid); end
    n_tests++; if (usb_tx_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h want=0", usb_tx_data); end
    n_tests++; if (rx_overflow !== '0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", rx_overflow); end
    n_tests++; if (periph_rx_fifo_full !== '0) begin n_fail++; $display("FAIL reset_full got=%b want=0", periph_rx_fifo_full); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b want=1", idle); end
  endtask

  task automatic test_single_write();
    do_reset();
    periph_rx_valid[2] = 1'b1; periph_rx_data[2] = 12'h05A;
    tick();
    clear_inputs();
    n_tests++; if (usb_tx_valid !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL single_store valid=%b idle=%b want 0/0", usb_tx_valid, idle); end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b1 || usb_tx_data !== 16'h205A) begin n_fail++; $display("FAIL single_out valid=%b data=%h want 1/205a", usb_tx_valid, usb_tx_data); end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b0 || idle !== 1'b1 || usb_tx_data !== 16'h205A) begin n_fail++; $display("FAIL single_after valid=%b idle=%b data=%h want 0/1/205a", usb_tx_valid, idle, usb_tx_data); end
  endtask

  task automatic test_fairness();
    int order [6];
    order = '{0, 1, 3, 0, 1, 3};
    do_reset();
    usb_tx_full = 1'b1;
    for (int r = 0; r < 2; r++) begin
      clear_inputs();
      periph_rx_valid = 4'b1011;
      tick();
    end
    clear_inputs();
    usb_tx_full = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_tests++;
      if (usb_tx_valid !== 1'b1 || usb_tx_data[UW-1 -: 4] !== 4'(order[j]) || usb_tx_data !== m_data) begin
        n_fail++; $display("FAIL fair_%0d valid=%b data=%h want 1/%h addr=%0d", j, usb_tx_valid, usb_tx_data, m_data, order[j]);
      end
    end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL fair_drain valid=%b idle=%b want 0/1", usb_tx_valid, idle); end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] pa, pb;
    pa = PW'($urandom); pb = PW'($urandom);
    do_reset();
    usb_tx_full = 1'b1;
    periph_rx_valid[1] = 1'b1; periph_rx_data[1] = pa; tick();
    periph_rx_data[1] = pb; tick();
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if (usb_tx_valid !== 1'b0 || periph_rx_fifo_full[1] !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_%0d valid=%b full1=%b want 0/1", c, usb_tx_valid, periph_rx_fifo_full[1]);
      end
    end
    usb_tx_full = 1'b0;
    tick();
    n_tests++; if (usb_tx_valid !== 1'b1 || usb_tx_data !== {4'h1, pa}) begin n_fail++; $display("FAIL bp_first valid=%b data=%h want 1/%h", usb_tx_valid, usb_tx_data, {4'h1, pa}); end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b1 || usb_tx_data !== {4'h1, pb}) begin n_fail++; $display("FAIL bp_second valid=%b data=%h want 1/%h", usb_tx_valid, usb_tx_data, {4'h1, pb}); end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end valid=%b want 0", usb_tx_valid); end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] px, py;
    px = PW'($urandom); py = PW'($urandom);
    do_reset();
    usb_tx_full = 1'b1;
    periph_rx_valid[0] = 1'b1; periph_rx_data[0] = px; tick();
    periph_rx_data[0] = py; tick();
    periph_rx_data[0] = 12'h111; tick();
    clear_inputs();
    n_tests++; if (rx_overflow[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want 1", rx_overflow[0]); end
    overflow_clear[0] = 1'b1; tick();
    clear_inputs();
    n_tests++; if (rx_overflow[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want 0", rx_overflow[0]); end
    periph_rx_valid[0] = 1'b1; overflow_clear[0] = 1'b1; tick();
    clear_inputs();
    n_tests++; if (rx_overflow[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b want 1", rx_overflow[0]); end
    usb_tx_full = 1'b0;
    tick();
    n_tests++; if (usb_tx_valid !== 1'b1 || usb_tx_data !== {4'h0, px}) begin n_fail++; $display("FAIL ovf_drain0 valid=%b data=%h want 1/%h", usb_tx_valid, usb_tx_data, {4'h0, px}); end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b1 || usb_tx_data !== {4'h0, py}) begin n_fail++; $display("FAIL ovf_drain1 valid=%b data=%h want 1/%h", usb_tx_valid, usb_tx_data, {4'h0, py}); end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL ovf_empty valid=%b idle=%b want 0/1", usb_tx_valid, idle); end
  endtask

  task automatic test_push_pop();
    logic [PW-1:0] pa, pb;
    pa = PW'($urandom); pb = PW'($urandom);
    do_reset();
    periph_rx_valid[3] = 1'b1; periph_rx_data[3] = pa; tick();
    periph_rx_data[3] = pb; tick();
    clear_inputs();
    n_tests++; if (usb_tx_valid !== 1'b1 || usb_tx_data !== {4'h3, pa} || periph_rx_fifo_full[3] !== 1'b0 || idle !== 1'b0) begin
      n_fail++; $display("FAIL pp_first valid=%b data=%h full3=%b idle=%b want 1/%h/0/0", usb_tx_valid, usb_tx_data, periph_rx_fifo_full[3], idle, {4'h3, pa});
    end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b1 || usb_tx_data !== {4'h3, pb}) begin n_fail++; $display("FAIL pp_second valid=%b data=%h want 1/%h", usb_tx_valid, usb_tx_data, {4'h3, pb}); end
    tick();
    n_tests++; if (usb_tx_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL pp_end valid=%b idle=%b want 0/1", usb_tx_valid, idle); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    usb_tx_full = 1'b1;
    periph_rx_valid = 4'b0111; tick();
    clear_inputs();
    periph_rx_valid = 4'b0001; tick();
    clear_inputs();
    usb_tx_full = 1'b0;
    tick();
    rst = 1'b1; periph_rx_valid = '1;
    tick();
    rst = 1'b0;
    clear_inputs();
    n_tests++; if (usb_tx_valid !== 1'b0 || idle !== 1'b1 || usb_tx_data !== '0 || periph_rx_fifo_full !== '0) begin
      n_fail++; $display("FAIL midrst valid=%b idle=%b data=%h full=%b want 0/1/0/0", usb_tx_valid, idle, usb_tx_data, periph_rx_fifo_full);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++; if (usb_tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_%0d valid=%b want 0", c, usb_tx_valid); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      usb_tx_full = ($urandom_range(0, 99) < 25);
      for (int i = 0; i < NP; i++) begin
        periph_rx_valid[i] = ($urandom_range(0, 99) < 30);
        overflow_clear[i]  = ($urandom_range(0, 99) < 10);
        periph_rx_data[i]  = PW'($urandom);
      end
      tick();
      n_tests++;
      if (usb_tx_valid !== m_valid || usb_tx_data !== m_data || rx_overflow !== m_ovf ||
          periph_rx_fifo_full !== exp_full() || idle !== exp_idle()) begin
        n_fail++;
        $display("FAIL rand_%0d valid=%b/%b data=%h/%h ovf=%b/%b full=%b/%b idle=%b/%b (got/want)", c,
                 usb_tx_valid, m_valid, usb_tx_data, m_data, rx_overflow, m_ovf,
                 periph_rx_fifo_full, exp_full(), idle, exp_idle());
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; usb_tx_full = 1'b0;
    periph_rx_valid = '0; overflow_clear = '0; periph_rx_data = '0;
    m_rr = 0; m_valid = 1'b0; m_data = '0; m_ovf = '0;
    for (int i = 0; i < NP; i++) begin m_cnt[i] = 0; m_buf[i][0] = '0; m_buf[i][1] = '0; end
    @(negedge clk);
    test_reset();
    test_single_write();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_push_pop();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lycan_rx_arbiter.md
LYCAN_RX_ARBITER -- requirements
Module: lycan_rx_arbiter

Interface
- REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset, with ports ordered as follows:
  - clk  input  1  sole clock; all state updates on rising edge.
  - rst  input  1  reset; synchronous, active-high.
- REQ-002 The block SHALL have the following peripheral-side ports:
  - periph_rx_data  input  [num_peripherals][usb_packet_width-periph_address_width]  per-peripheral payload, address not included.
  - periph_rx_valid  input  [num_peripherals]  per-peripheral write strobe.
  - periph_rx_fifo_full  output  [num_peripherals]  per-peripheral backpressure.
- REQ-003 The block SHALL have the following USB-side ports:
  - usb_tx_data  output  usb_packet_width  packet {address, payload}.
  - usb_tx_valid  output  1  one-cycle write strobe into the USB TX FIFO.
  - usb_tx_full  input  1  USB TX FIFO full.
- REQ-004 The block SHALL have the following status ports:
  - rx_overflow  output  [num_peripherals]  sticky dropped-write flag per peripheral.
  - overflow_clear  input  [num_peripherals]  per-bit clear pulse for rx_overflow.
  - idle  output  1  high when all buffers are empty and usb_tx_valid is low.

Function
- REQ-005 Each peripheral SHALL own a 2-entry FIFO buffer storing payload only.
- REQ-006 periph_rx_fifo_full[i] SHALL equal (count[i]==2), decoded combinationally from the registered count.
- REQ-007 A write SHALL be accepted when periph_rx_valid[i]=1 and count[i]<2.
- REQ-008 A write attempted with count[i]==2 SHALL be dropped and SHALL set rx_overflow[i] on the next edge, even if a pop occurs in the same cycle.
- REQ-009 A push and pop on the same cycle with count 1 SHALL leave count at 1 and preserve FIFO order.
- REQ-010 Arbitration SHALL run every cycle with usb_tx_full=0, granting the first non-empty buffer searching from rr_ptr upward, modulo num_peripherals.
- REQ-011 After a grant to buffer g, rr_ptr SHALL become (g+1) mod num_peripherals; with no grant, rr_ptr SHALL hold.
- REQ-012 With usb_tx_full=1, no grant SHALL occur, and buffer and rr_ptr state SHALL hold.
- REQ-013 The granted entry SHALL be popped, and on the next edge usb_tx_data SHALL load {g[periph_address_width-1:0], payload} with the address in the MSBs, and usb_tx_valid SHALL load 1.
- REQ-014 Latency from an accepted write into an empty system to usb_tx_valid SHALL be 2 cycles: one cycle to store, one cycle to register the output.
- REQ-015 usb_tx_valid SHALL be high for exactly one cycle per granted packet, and SHALL be 0 in any cycle following a no-grant cycle.
- REQ-016 usb_tx_data SHALL hold its last value when usb_tx_valid=0.
- REQ-017 Sustained throughput SHALL be one packet per cycle while usb_tx_full=0 and any buffer is non-empty.
- REQ-018 overflow_clear[i] SHALL clear rx_overflow[i]; a simultaneous set SHALL take priority over the clear.
- REQ-019 idle SHALL be combinational: all count[i]==0 and usb_tx_valid==0.
- REQ-020 With num_peripherals=1, the block SHALL degenerate to a single FIFO buffer with the address field zero.

Reset
- REQ-021 During reset, all FIFO buffers SHALL empty (count=0), rr_ptr SHALL be 0, usb_tx_valid SHALL be 0, usb_tx_data SHALL be 0, and rx_overflow SHALL be 0.
- REQ-022 After reset: periph_rx_fifo_full=0 and idle=1.
- REQ-023 Writes presented during the reset cycle SHALL be discarded and SHALL NOT set rx_overflow.
- REQ-024 Reset mid-burst SHALL drop all buffered packets, with no partial output.

Structure
- REQ-025 usb_packet_width, periph_address_width and num_peripherals SHALL come from package lycan_globals; the requirement num_peripherals <= 2**periph_address_width SHALL be checked by an elaboration assertion.
- REQ-026 The 2-entry FIFO buffer SHALL be a sub-module periph_rx_buffer, instantiated once per peripheral, with ports for push, pop, data, count and full.
- REQ-027 The round-robin search SHALL be combinational, and no other submodules SHALL be used.

Verification
- REQ-028 Single write: after reset, write 0x05A to peripheral 2 → usb_tx_valid pulses one cycle later than storage, usb_tx_data = {2, 0x05A}, idle returns to 1.
- REQ-029 Fairness: peripherals 0, 1 and 3 each hold 2 entries, rr_ptr=0 → grant order 0,1,3,0,1,3 on six consecutive cycles.
- REQ-030 Backpressure: usb_tx_full=1 for 10 cycles with 2 entries in peripheral 1 → no usb_tx_valid, fifo_full[1]=1; release → two packets on consecutive cycles, in order.
- REQ-031 Overflow: peripheral 0 full, usb_tx_full=1, write 0x111 → write dropped, rx_overflow[0]=1; assert overflow_clear[0] with no new overflow → 0; assert overflow_clear[0] in the same cycle as another dropped write → stays 1.
- REQ-032 Same-cycle push/pop at count 1 on peripheral 3, payloads A then B → count stays 1, outputs A then B.
- REQ-033 Reset while 3 peripherals are non-empty → next cycle usb_tx_valid=0, all counts 0, no stale packet emitted afterwards.
